fetch: RTL
==========

// Module: fetch
// PURPOSE
//  Instruction-fetch stage. Holds the PC, issues req/ack reads to the instruction
//  memory controller and loads the IF/ID register (if_id_instruc, if_id_nextpc)
//  read by Decode. Applies Decode's redirect (id_if_selpcsource/selpctype) with
//  one-delay-slot semantics. Inserts NOP bubbles during memory wait states.
// PARAMETERS
//  RESET_PC    32'h0000_0000  first fetch address after reset
//  EXC_VECTOR  32'h0000_0080  target when id_if_selpctype = 2'b11
//  NOP_INSTR   32'h0000_0000  bubble loaded into if_id_instruc when no ack
// PORTS
//  clock              in   1   clock, rising edge
//  reset              in   1   async reset, active low
//  id_if_selpcsource  in   1   1 = redirect PC this cycle
//  id_if_selpctype    in   2   00 pcimd2ext, 01 rega, 10 pcindex, 11 EXC_VECTOR
//  id_if_pcimd2ext    in   32  branch target
//  id_if_rega         in   32  register target (jr/jalr)
//  id_if_pcindex      in   32  jump-index target
//  if_mc_req          out  1   read request, held until ack
//  if_mc_addr         out  32  word address of request (= PC, bits[1:0] = 00)
//  mc_if_ack          in   1   read done; mc_if_data valid this cycle
//  mc_if_data         in   32  instruction word
//  if_id_instruc      out  32  IF/ID instruction register
//  if_id_nextpc       out  32  IF/ID PC+4 of that instruction
// BEHAVIOUR
//  Reset (reset=0, async): pc=RESET_PC, state=BOOT, pend=0, ptarget=0,
//   if_id_instruc=NOP_INSTR, if_id_nextpc=0, if_mc_req=0.
//  target = mux(selpctype) of the four sources, bits[1:0] forced to 00.
//  FSM (registered state):
//   BOOT : req=0; next cycle -> FETCH (exactly one idle cycle after reset release).
//   FETCH: req=1, addr=pc.
//     ack & !redir: IF/ID<={data,pc+4}; pc<=pc+4; stay.
//     ack &  redir: IF/ID<={data,pc+4}; pc<=target; stay (fetched word = delay slot).
//     !ack & redir: IF/ID<=NOP; ptarget<=target; pend=1 -> PEND; pc holds.
//     !ack & !redir: IF/ID<=NOP (nextpc holds); pc holds.
//   PEND : req=1, addr=pc (delay-slot fetch outstanding).
//     ack: IF/ID<={data,pc+4}; pc<=ptarget; pend=0 -> FETCH.
//     !ack: IF/ID<=NOP; if redir, ptarget<=target (latest wins).
//  Handshake: addr stable while req=1 and no ack; zero-wait ack (same cycle as
//   req rise) legal; ack while req=0 ignored. Ack consumed exactly once.
//  Latency: zero-wait memory -> instruction at addr A in IF/ID one edge after
//   the A request cycle; throughput 1 instr/cycle.
//  Arithmetic: pc+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0, no flag).
//  Redirect visible to Decode once only (bubbles follow a branch), hence pend.
//  Reset mid-wait: outstanding request abandoned; late ack after reset ignored
//   (BOOT has req=0).
// TESTING
//  1 Reset release, ack tied 1, data=addr^32'hA5A5_0000 -> req 0 one cycle, then
//    addr 0,4,8,...; if_id_nextpc 4,8,12 on consecutive edges.
//  2 IF/ID=beq at 0x10 (nextpc 0x14), redir=1 type 00 target 0x40, ack=1 ->
//    next IF/ID=word@0x14 (delay slot), following addr = 0x40.
//  3 Same branch, ack low 3 cycles -> IF/ID=NOP x3, addr stays 0x14, state PEND;
//    on ack IF/ID=word@0x14, next addr 0x40.
//  4 selpctype 01 rega=0x1003 / 10 pcindex=0x0800_0100 / 11 -> next addr
//    0x1000 / 0x0800_0100 / 0x80.
//  5 pc=0xFFFF_FFFC, ack=1 -> if_id_nextpc=0, next addr 0.
//  6 reset asserted during 2-cycle wait at 0x20, late ack on release edge ->
//    IF/ID=NOP, first addr after BOOT = RESET_PC.

Source files
------------

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC and issues req/ack reads to the
// instruction memory controller. It also loads the IF/ID register and applies
// Decode's redirect with a single branch delay slot.
module fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        id_if_selpcsource,
    input  logic [1:0]  id_if_selpctype,
    input  logic [31:0] id_if_pcimd2ext,
    input  logic [31:0] id_if_rega,
    input  logic [31:0] id_if_pcindex,
    output logic        if_mc_req,
    output logic [31:0] if_mc_addr,
    input  logic        mc_if_ack,
    input  logic [31:0] mc_if_data,
    output logic [31:0] if_id_instruc,
    output logic [31:0] if_id_nextpc
);

    // BOOT gives one idle cycle after reset; PEND means a redirect arrived
    // while the delay-slot fetch was still outstanding.
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_PEND  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ptarget_q, ptarget_d;
    logic [31:0] instruc_q, instruc_d;
    logic [31:0] nextpc_q, nextpc_d;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    // Redirect target selection, always word aligned
    always_comb begin
        target = id_if_pcimd2ext;
        unique case (id_if_selpctype)
            2'b00: target = id_if_pcimd2ext;
            2'b01: target = id_if_rega;
            2'b10: target = id_if_pcindex;
            2'b11: target = EXC_VECTOR;
            default: target = id_if_pcimd2ext;
        endcase
        target[1:0] = 2'b00;
    end

    // Sequential PC increment, wraps modulo 2^32
    assign pc_plus4 = pc_q + 32'd4;

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_BOOT;
        else        state_q <= state_d;
    end

    // Next-state logic
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BOOT:  state_d = ST_FETCH;
            ST_FETCH: if (!mc_if_ack && id_if_selpcsource) state_d = ST_PEND;
            ST_PEND:  if (mc_if_ack) state_d = ST_FETCH;
            default:  state_d = ST_BOOT;
        endcase
    end

    // Outputs decoded from state: request in every state except BOOT
    always_comb begin
        if_mc_req = (state_q != ST_BOOT);
    end

    assign if_mc_addr    = {pc_q[31:2], 2'b00};
    assign if_id_instruc = instruc_q;
    assign if_id_nextpc  = nextpc_q;

    // Datapath next values: PC, pending target and IF/ID contents
    always_comb begin
        pc_d      = pc_q;
        ptarget_d = ptarget_q;
        instruc_d = instruc_q;
        nextpc_d  = nextpc_q;
        unique case (state_q)
            ST_FETCH: begin
                if (mc_if_ack) begin
                    instruc_d = mc_if_data;
                    nextpc_d  = pc_plus4;
                    pc_d      = id_if_selpcsource ? target : pc_plus4;
                end else begin
                    instruc_d = NOP_INSTR;
                    if (id_if_selpcsource) ptarget_d = target;
                end
            end
            ST_PEND: begin
                if (mc_if_ack) begin
                    instruc_d = mc_if_data;
                    nextpc_d  = pc_plus4;
                    pc_d      = ptarget_q;
                end else begin
                    instruc_d = NOP_INSTR;
                    if (id_if_selpcsource) ptarget_d = target;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q      <= RESET_PC;
            ptarget_q <= 32'h0;
            instruc_q <= NOP_INSTR;
            nextpc_q  <= 32'h0;
        end else begin
            pc_q      <= pc_d;
            ptarget_q <= ptarget_d;
            instruc_q <= instruc_d;
            nextpc_q  <= nextpc_d;
        end
    end

endmodule
